gin_id_config_ctrl: RTL and testbench



---
 rtl/gin_cfg_pkg.sv | 24 ++
 rtl/gin_cfg_addr_gen.sv | 37 +++
 rtl/gin_id_config_ctrl.sv | 148 ++++++++++++++
 tb/tb_gin_id_config_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/gin_cfg_pkg.sv
// Shared types and address-map helpers for the GIN ID configuration sequencer.
package gin_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      Y_RD  = 3'd1,
      X_RD  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } gin_cfg_state_e;

   localparam int unsigned Y_BASE = 0;

   // The X table starts right after the Y table, one entry per row bus.
   function automatic int unsigned x_base(input int unsigned rows);
      return rows;
   endfunction

   function automatic int unsigned total_shifts(input int unsigned rows,
                                                input int unsigned cols);
      return rows + rows * cols;
   endfunction

endpackage

// File: rtl/gin_cfg_addr_gen.sv
// Loadable down-counter with zero flag; the address is the count plus a base offset.
module gin_cfg_addr_gen #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] load_val_i,
   input  logic              dec_i,
   input  logic [ADDR_W-1:0] base_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              zero_o
);

   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign addr_o = base_i + cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gin_id_config_ctrl.sv
// GIN ID scan-chain configuration sequencer: reads Y/X ID tables and shifts them into the chains.
// Optional abort input/cfg_aborted output enabled by GIN_ID_CFG_ABORT_EN.
module gin_id_config_ctrl
   import gin_cfg_pkg::*;
#(
   parameter int unsigned NUMS_PE_ROW = 6,
   parameter int unsigned NUMS_PE_COL = 8,
   parameter int unsigned XID_BITS    = 4,
   parameter int unsigned YID_BITS    = 4,
   parameter int unsigned ID_W        = 8,
   parameter int unsigned ADDR_W      = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
`ifdef GIN_ID_CFG_ABORT_EN
   input  logic                abort,
   output logic                cfg_aborted,
`endif
   output logic                cfg_busy,
   output logic                cfg_done,
   output logic                id_rd_en,
   output logic [ADDR_W-1:0]   id_rd_addr,
   input  logic [ID_W-1:0]     id_rd_data,
   output logic                set_YID,
   output logic [YID_BITS-1:0] YID_scan_in,
   output logic                set_XID,
   output logic [XID_BITS-1:0] XID_scan_in
);

   localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(NUMS_PE_ROW - 1);
   localparam logic [ADDR_W-1:0] X_LAST =
      ADDR_W'(total_shifts(NUMS_PE_ROW, NUMS_PE_COL) - x_base(NUMS_PE_ROW) - 1);
   localparam logic [ADDR_W-1:0] Y_OFF  = ADDR_W'(Y_BASE);
   localparam logic [ADDR_W-1:0] X_OFF  = ADDR_W'(x_base(NUMS_PE_ROW));

   gin_cfg_state_e state_q, state_d;
   logic yshift_q, yshift_d;
   logic xshift_q, xshift_d;
   logic aborted_q, aborted_d;

   logic              cnt_load, cnt_dec, cnt_zero;
   logic [ADDR_W-1:0] cnt_load_val, cnt_base, gen_addr;
   logic              busy;
   logic              unused_rd_hi;

   gin_cfg_addr_gen #(
      .ADDR_W(ADDR_W)
   ) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .load_i    (cnt_load),
      .load_val_i(cnt_load_val),
      .dec_i     (cnt_dec),
      .base_i    (cnt_base),
      .addr_o    (gen_addr),
      .zero_o    (cnt_zero)
   );

   assign busy = (state_q == Y_RD) || (state_q == X_RD) || (state_q == DRAIN);

   always_comb begin
      state_d      = state_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;
      yshift_d     = 1'b0;
      xshift_d     = 1'b0;
      aborted_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = Y_RD;
               cnt_load     = 1'b1;
               cnt_load_val = Y_LAST;
            end
         end
         Y_RD: begin
            yshift_d = 1'b1;
            if (cnt_zero) begin
               state_d      = X_RD;
               cnt_load     = 1'b1;
               cnt_load_val = X_LAST;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         X_RD: begin
            xshift_d = 1'b1;
            if (cnt_zero) begin
               state_d = DRAIN;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef GIN_ID_CFG_ABORT_EN
      // Abort drops the in-flight read by never raising its shift flag.
      if (abort && busy) begin
         state_d   = IDLE;
         cnt_load  = 1'b0;
         cnt_dec   = 1'b0;
         yshift_d  = 1'b0;
         xshift_d  = 1'b0;
         aborted_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         yshift_q  <= 1'b0;
         xshift_q  <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         yshift_q  <= yshift_d;
         xshift_q  <= xshift_d;
         aborted_q <= aborted_d;
      end
   end

   assign cnt_base    = (state_q == X_RD) ? X_OFF : Y_OFF;
   assign id_rd_en    = (state_q == Y_RD) || (state_q == X_RD);
   assign id_rd_addr  = id_rd_en ? gen_addr : '0;
   assign cfg_busy    = busy;
   assign cfg_done    = (state_q == DONE);

   // Read data arrives the cycle after the strobe, so it feeds the chain directly.
   assign set_YID     = yshift_q;
   assign YID_scan_in = yshift_q ? id_rd_data[YID_BITS-1:0] : '0;
   assign set_XID     = xshift_q;
   assign XID_scan_in = xshift_q ? id_rd_data[XID_BITS-1:0] : '0;

   assign unused_rd_hi = ^id_rd_data;

`ifdef GIN_ID_CFG_ABORT_EN
   assign cfg_aborted = aborted_q;
`else
   logic unused_aborted;
   assign unused_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_gin_id_config_ctrl.sv
// Directed bench for gin_id_config_ctrl with R=2, C=3; abort tests under GIN_ID_CFG_ABORT_EN.
module tb_gin_id_config_ctrl;

   localparam int unsigned R = 2;
   localparam int unsigned C = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       cfg_busy, cfg_done, id_rd_en;
   logic [7:0] id_rd_addr;
   logic [7:0] id_rd_data;
   logic       set_YID, set_XID;
   logic [3:0] YID_scan_in, XID_scan_in;
   logic       cfg_aborted;
`ifdef GIN_ID_CFG_ABORT_EN
   logic       abort;
`else
   assign cfg_aborted = 1'b0;
`endif

   always #5 clk = ~clk;

   gin_id_config_ctrl #(
      .NUMS_PE_ROW(R),
      .NUMS_PE_COL(C),
      .XID_BITS   (4),
      .YID_BITS   (4),
      .ID_W       (8),
      .ADDR_W     (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
`ifdef GIN_ID_CFG_ABORT_EN
      .abort      (abort),
      .cfg_aborted(cfg_aborted),
`endif
      .cfg_busy   (cfg_busy),
      .cfg_done   (cfg_done),
      .id_rd_en   (id_rd_en),
      .id_rd_addr (id_rd_addr),
      .id_rd_data (id_rd_data),
      .set_YID    (set_YID),
      .YID_scan_in(YID_scan_in),
      .set_XID    (set_XID),
      .XID_scan_in(XID_scan_in)
   );

   // Config buffer: Y table {1,2} at 0..1, X table {10..15} at 2..7.
   logic [7:0] mem [8];
   initial begin
      mem[0] = 8'd1;  mem[1] = 8'd2;
      mem[2] = 8'd10; mem[3] = 8'd11; mem[4] = 8'd12;
      mem[5] = 8'd13; mem[6] = 8'd14; mem[7] = 8'd15;
      id_rd_data = 8'h00;
   end

   always @(posedge clk) begin
      if (id_rd_en) id_rd_data <= mem[id_rd_addr[2:0]];
   end

   // GIN scan chains: data enters slave 0 and ripples toward the last slave.
   logic [3:0] ychain [R];
   logic [3:0] xchain [R*C];
   always @(posedge clk) begin
      if (set_YID) begin
         for (int i = R - 1; i > 0; i--) ychain[i] <= ychain[i-1];
         ychain[0] <= YID_scan_in;
      end
      if (set_XID) begin
         for (int i = R*C - 1; i > 0; i--) xchain[i] <= xchain[i-1];
         xchain[0] <= XID_scan_in;
      end
   end

   logic [21:0] obs;
   assign obs = {cfg_aborted, cfg_busy, cfg_done, id_rd_en, id_rd_addr,
                 set_YID, YID_scan_in, set_XID, XID_scan_in};

   int n_tests = 0;
   int n_fail  = 0;
   int rd_cnt, done_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected output word r cycles after an accepted start (hand-derived timeline).
   function automatic logic [21:0] expw(input int r, input int ab, input logic [3:0] x5);
      logic       abt, busy, done, rd, sy, sx;
      logic [7:0] a;
      logic [3:0] yd, xd;
      abt = 0; busy = 0; done = 0; rd = 0; sy = 0; sx = 0;
      a = '0; yd = '0; xd = '0;
      if (ab >= 0 && r > ab) begin
         abt = (r == ab + 1);
      end else begin
         busy = (r >= 1 && r <= 9);
         done = (r == 10);
         rd   = (r >= 1 && r <= 8);
         if (rd) a = (r == 1) ? 8'd1 : (r == 2) ? 8'd0 : 8'(10 - r);
         sy = (r == 2 || r == 3);
         yd = (r == 2) ? 4'd2 : (r == 3) ? 4'd1 : 4'd0;
         sx = (r >= 4 && r <= 9);
         if (sx) xd = (r == 6) ? x5 : 4'(19 - r);
      end
      return {abt, busy, done, rd, a, sy, yd, sx, xd};
   endfunction

   // Entered and left at posedge+1; k counts cycles from the first start.
   task automatic run_seq(input string name, input int ncyc, input int s2,
                          input int ign1, input int ign2, input int ab,
                          input int rst_at, input logic [3:0] x5);
      int r;
      rd_cnt = 0;
      done_cnt = 0;
      for (int k = 0; k < ncyc; k++) begin
         start = (k == 0) || (k == s2) || (k == ign1) || (k == ign2);
`ifdef GIN_ID_CFG_ABORT_EN
         abort = (k == ab);
`endif
         if (k == rst_at) begin
            rst = 1'b1;
            #1;
            check($sformatf("%s_rst_cyc%0d", name, k), 32'(obs), 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            start = 1'b0;
            return;
         end
         r = (s2 >= 0 && k >= s2) ? k - s2 : k;
         @(negedge clk);
         if (id_rd_en) rd_cnt++;
         if (cfg_done) done_cnt++;
         check($sformatf("%s_cyc%0d", name, k), 32'(obs), 32'(expw(r, ab, x5)));
         @(posedge clk); #1;
      end
      start = 1'b0;
`ifdef GIN_ID_CFG_ABORT_EN
      abort = 1'b0;
`endif
   endtask

   task automatic chk_chains(input string name, input logic [3:0] x3);
      logic [3:0] xe [6];
      xe = '{4'd10, 4'd11, 4'd12, x3, 4'd14, 4'd15};
      check({name, "_Y0"}, 32'(ychain[0]), 32'd1);
      check({name, "_Y1"}, 32'(ychain[1]), 32'd2);
      for (int i = 0; i < 6; i++)
         check($sformatf("%s_X%0d", name, i), 32'(xchain[i]), 32'(xe[i]));
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
`ifdef GIN_ID_CFG_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("reset_in", 32'(obs), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("reset_out", 32'(obs), 32'd0);
      @(posedge clk); #1;

      // Single run with starts at cycles 3 and 10 that must be ignored.
      run_seq("A", 14, -1, 3, 10, -1, -1, 4'd13);
      check("A_reads", 32'(rd_cnt), 32'd8);
      check("A_dones", 32'(done_cnt), 32'd1);
      chk_chains("A", 4'd13);

      // Back-to-back runs: second start lands in the first IDLE cycle.
      run_seq("B", 24, 11, -1, -1, -1, -1, 4'd13);
      check("B_reads", 32'(rd_cnt), 32'd16);
      check("B_dones", 32'(done_cnt), 32'd2);
      chk_chains("B", 4'd13);

      // Upper data bits must not reach the 4-bit scan data.
      mem[5] = 8'hF7;
      run_seq("C", 13, -1, -1, -1, -1, -1, 4'h7);
      chk_chains("C", 4'h7);
      mem[5] = 8'd13;

      // Asynchronous reset mid-sequence, then a full rerun.
      run_seq("D", 12, -1, -1, -1, -1, 5, 4'd13);
      @(negedge clk);
      check("D_idle", 32'(obs), 32'd0);
      @(posedge clk); #1;
      run_seq("D2", 13, -1, -1, -1, -1, -1, 4'd13);
      check("D2_reads", 32'(rd_cnt), 32'd8);
      chk_chains("D2", 4'd13);

`ifdef GIN_ID_CFG_ABORT_EN
      run_seq("E", 13, -1, -1, -1, 5, -1, 4'd13);
      check("E_reads", 32'(rd_cnt), 32'd5);
      check("E_dones", 32'(done_cnt), 32'd0);
      run_seq("E2", 13, -1, -1, -1, -1, -1, 4'd13);
      chk_chains("E2", 4'd13);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
